// File: rtl/dispatch_queue.sv
// In-order multi-lane dispatch buffer: up to WAYS packets in and WAYS out per cycle, circular over DEPTH entries.
// Latency: a packet accepted on one edge is visible on out_valid/out_data after that edge (no bypass).
// Backpressure: in_ready_cnt is credit-style, derived from registered occupancy only; dispatch takes a clamped prefix.
module dispatch_queue #(
    parameter int WAYS    = 2,
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WAYS-1:0]            in_valid,
    input  logic [WAYS*ENTRY_W-1:0]    in_data,
    output logic [$clog2(WAYS+1)-1:0]  in_ready_cnt,
    output logic [WAYS-1:0]            out_valid,
    output logic [WAYS*ENTRY_W-1:0]    out_data,
    input  logic [$clog2(WAYS+1)-1:0]  take_cnt,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(WAYS + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
    localparam logic [NW-1:0] WAYS_N  = NW'(WAYS);
    localparam logic [CW-1:0] WAYS_C  = CW'(WAYS);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [NW-1:0]      count_q, count_d;

    logic [NW-1:0]      free_slots;
    logic [CW-1:0]      ready_cnt;
    logic [CW-1:0]      prefix_len;
    logic [CW-1:0]      acc;
    logic [CW-1:0]      deq;

    // Credits come from the pre-dequeue occupancy, so a full queue that is draining still offers zero this cycle.
    always_comb begin
        free_slots = DEPTH_N - count_q;
        ready_cnt  = (free_slots >= WAYS_N) ? WAYS_C : free_slots[CW-1:0];
    end

    // Accepted lanes are the contiguous valid run from lane 0, limited by the available credits.
    always_comb begin
        logic run;
        prefix_len = '0;
        run        = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (run && in_valid[i]) begin
                prefix_len = prefix_len + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
        acc = (prefix_len < ready_cnt) ? prefix_len : ready_cnt;
    end

    // Dispatch can never remove more than is held; when clamped, the occupancy itself fits in CW bits.
    always_comb begin
        deq = (NW'(take_cnt) < count_q) ? take_cnt : count_q[CW-1:0];
    end

    // Pointer/occupancy next state; flush discards everything and overrides any enqueue or dequeue.
    always_comb begin
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(acc);
        count_d = count_q + NW'(acc) - NW'(deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state with asynchronous clear; storage is left untouched by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write accepted lanes at consecutive slots from tail; pointer arithmetic wraps on the power-of-two depth.
    always_ff @(posedge clock) begin
        if (reset && !flush) begin
            for (int i = 0; i < WAYS; i++) begin
                if (CW'(i) < acc) begin
                    mem_q[tail_q + PW'(i)] <= in_data[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    // Present the oldest entries from head; invalid lanes are forced to zero.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < WAYS; i++) begin
            out_valid[i] = (count_q > NW'(i));
            if (out_valid[i]) begin
                out_data[i*ENTRY_W +: ENTRY_W] = mem_q[head_q + PW'(i)];
            end
        end
    end

    assign in_ready_cnt = ready_cnt;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_N);

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue (WAYS=2, DEPTH=8, ENTRY_W=32).
// Table-driven vectors checked after each edge, plus hand sequences for wrap-around and async reset.
// Outputs are sampled 1 time unit after the rising edge.
module tb_dispatch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [63:0] in_data = '0;
    logic [1:0]  in_ready_cnt;
    logic [1:0]  out_valid;
    logic [63:0] out_data;
    logic [1:0]  take_cnt = '0;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    int n_chk  = 0;
    int n_fail = 0;

    dispatch_queue #(.WAYS(2), .DEPTH(8), .ENTRY_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready_cnt (in_ready_cnt),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .take_cnt     (take_cnt),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        fl;
        logic [1:0]  iv;
        logic [63:0] id;
        logic [1:0]  tk;
        logic [3:0]  cnt;
        logic [1:0]  ov;
        logic [63:0] od;
        logic [1:0]  rdy;
        logic        em;
        logic        fu;
    } vec_t;

    vec_t vt[17];

    function automatic logic [31:0] dv(input logic [3:0] tag, input int n);
        return {tag, 28'(n)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic [1:0] ov,
                             input logic [63:0] od, input logic [1:0] rdy,
                             input logic em, input logic fu);
        chk({tag, " count"}, 64'(count), 64'(c));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, " out_data"}, out_data, od);
        chk({tag, " in_ready_cnt"}, 64'(in_ready_cnt), 64'(rdy));
        chk({tag, " empty"}, 64'(empty), 64'(em));
        chk({tag, " full"}, 64'(full), 64'(fu));
    endtask

    task automatic step(input logic fl, input logic [1:0] iv, input logic [63:0] id, input logic [1:0] tk);
        flush    = fl;
        in_valid = iv;
        in_data  = id;
        take_cnt = tk;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = '0;
        in_data  = '0;
        take_cnt = '0;
    endtask

    initial begin
        //        fl    iv     in_data                       tk     cnt  ov     out_data                      rdy    em    fu
        vt[0]  = '{1'b0, 2'b11, {dv(4'hA,1), dv(4'hA,0)}, 2'd0, 4'd2, 2'b11, {dv(4'hA,1), dv(4'hA,0)}, 2'd2, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 2'b11, {dv(4'hA,3), dv(4'hA,2)}, 2'd0, 4'd4, 2'b11, {dv(4'hA,1), dv(4'hA,0)}, 2'd2, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 2'b11, {dv(4'hA,5), dv(4'hA,4)}, 2'd0, 4'd6, 2'b11, {dv(4'hA,1), dv(4'hA,0)}, 2'd2, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 2'b11, {dv(4'hA,7), dv(4'hA,6)}, 2'd0, 4'd8, 2'b11, {dv(4'hA,1), dv(4'hA,0)}, 2'd0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 2'b11, {dv(4'hA,9), dv(4'hA,8)}, 2'd0, 4'd8, 2'b11, {dv(4'hA,1), dv(4'hA,0)}, 2'd0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 2'b11, {dv(4'hA,9), dv(4'hA,8)}, 2'd2, 4'd6, 2'b11, {dv(4'hA,3), dv(4'hA,2)}, 2'd2, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 2'b00, 64'h0,                    2'd2, 4'd4, 2'b11, {dv(4'hA,5), dv(4'hA,4)}, 2'd2, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 2'b00, 64'h0,                    2'd1, 4'd3, 2'b11, {dv(4'hA,6), dv(4'hA,5)}, 2'd2, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 2'b10, {dv(4'hB,1), dv(4'hB,0)}, 2'd2, 4'd1, 2'b01, {32'h0, dv(4'hA,7)},      2'd2, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 2'b00, 64'h0,                    2'd2, 4'd0, 2'b00, 64'h0,                    2'd2, 1'b1, 1'b0};
        vt[10] = '{1'b0, 2'b10, {dv(4'hB,1), dv(4'hB,0)}, 2'd0, 4'd0, 2'b00, 64'h0,                    2'd2, 1'b1, 1'b0};
        vt[11] = '{1'b0, 2'b01, {dv(4'hB,1), dv(4'hC,0)}, 2'd0, 4'd1, 2'b01, {32'h0, dv(4'hC,0)},      2'd2, 1'b0, 1'b0};
        vt[12] = '{1'b0, 2'b11, {dv(4'hC,2), dv(4'hC,1)}, 2'd1, 4'd2, 2'b11, {dv(4'hC,2), dv(4'hC,1)}, 2'd2, 1'b0, 1'b0};
        vt[13] = '{1'b0, 2'b01, {dv(4'hB,1), dv(4'hC,3)}, 2'd0, 4'd3, 2'b11, {dv(4'hC,2), dv(4'hC,1)}, 2'd2, 1'b0, 1'b0};
        vt[14] = '{1'b0, 2'b11, {dv(4'hC,5), dv(4'hC,4)}, 2'd0, 4'd5, 2'b11, {dv(4'hC,2), dv(4'hC,1)}, 2'd2, 1'b0, 1'b0};
        vt[15] = '{1'b1, 2'b11, {dv(4'hB,1), dv(4'hB,0)}, 2'd1, 4'd0, 2'b00, 64'h0,                    2'd2, 1'b1, 1'b0};
        vt[16] = '{1'b0, 2'b01, {32'h0, dv(4'hD,0)},      2'd0, 4'd1, 2'b01, {32'h0, dv(4'hD,0)},      2'd2, 1'b0, 1'b0};

        // Reset state while reset is held low.
        #12;
        check_all("reset", 4'd0, 2'b00, 64'h0, 2'd2, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Fill, full hold, simultaneous at full, drain, non-prefix, clamp, flush priority.
        for (int i = 0; i < 17; i++) begin
            step(vt[i].fl, vt[i].iv, vt[i].id, vt[i].tk);
            check_all($sformatf("v%0d", i), vt[i].cnt, vt[i].ov, vt[i].od, vt[i].rdy, vt[i].em, vt[i].fu);
        end

        // Wrap-around: clear, then stream pairs in and out for 20 cycles across several pointer wraps.
        step(1'b1, 2'b00, 64'h0, 2'd0);
        chk("wrap flush count", 64'(count), 64'd0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 2'b11, {32'(2*k+1), 32'(2*k)}, 2'd2);
            chk($sformatf("wrap%0d lane0", k), 64'(out_data[31:0]), 64'(2*k));
            chk($sformatf("wrap%0d lane1", k), 64'(out_data[63:32]), 64'(2*k+1));
            chk($sformatf("wrap%0d count", k), 64'(count), 64'd2);
        end
        step(1'b0, 2'b00, 64'h0, 2'd2);
        chk("wrap drained", 64'(count), 64'd0);

        // Async reset between edges with three entries held.
        step(1'b0, 2'b11, {dv(4'hE,1), dv(4'hE,0)}, 2'd0);
        step(1'b0, 2'b01, {32'h0, dv(4'hE,2)}, 2'd0);
        chk("pre-reset count", 64'(count), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check_all("async", 4'd0, 2'b00, 64'h0, 2'd2, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        step(1'b0, 2'b00, 64'h0, 2'd0);
        check_all("post-reset idle", 4'd0, 2'b00, 64'h0, 2'd2, 1'b1, 1'b0);
        step(1'b0, 2'b01, {32'h0, dv(4'hF,0)}, 2'd0);
        check_all("post-reset enq", 4'd1, 2'b01, {32'h0, dv(4'hF,0)}, 2'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
